// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, RV32I opcodes, operand-select and immediate-kind types shared by the issue stage.
package alu_pkg;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t op_ADD  = 4'b0000;
  localparam alu_op_t op_SLL  = 4'b0001;
  localparam alu_op_t op_SLT  = 4'b0010;
  localparam alu_op_t op_SLTU = 4'b0011;
  localparam alu_op_t op_XOR  = 4'b0100;
  localparam alu_op_t op_SRL  = 4'b0101;
  localparam alu_op_t op_OR   = 4'b0110;
  localparam alu_op_t op_AND  = 4'b0111;
  localparam alu_op_t op_SUB  = 4'b1000;
  localparam alu_op_t op_SRA  = 4'b1101;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_t;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_ZERO} b_sel_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_U, IMM_SH, IMM_4} imm_kind_t;
  // IMM_4 is the link offset for JAL/JALR; IMM_SH keeps only the shamt.
  function automatic logic [31:0] imm_gen(input imm_kind_t k, input logic [31:0] i);
    return k == IMM_S  ? {{20{i[31]}}, i[31:25], i[11:7]} :
           k == IMM_U  ? {i[31:12], 12'b0} :
           k == IMM_SH ? {27'b0, i[24:20]} :
           k == IMM_4  ? 32'd4 :
                         {{20{i[31]}}, i[31:20]};
  endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational RV32I instruction to ALU control, operand selects, immediate and rd write enable.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     alu_ctrl,
  output a_sel_t      a_sel,
  output b_sel_t      b_sel,
  output logic [31:0] imm,
  output logic        rd_we,
  output logic        illegal
);
  logic [2:0] f3;
  logic       base_we;
  imm_kind_t  kind;
  assign f3 = instr[14:12];
  always_comb begin
    alu_ctrl = op_ADD;
    a_sel    = A_ZERO;
    b_sel    = B_ZERO;
    kind     = IMM_I;
    base_we  = 1'b0;
    illegal  = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        alu_ctrl = {instr[30], f3};
        a_sel    = A_RS1;
        b_sel    = B_RS2;
        base_we  = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_ctrl = (f3 == 3'b101 && instr[30]) ? op_SRA : {1'b0, f3};
        a_sel    = A_RS1;
        b_sel    = B_IMM;
        kind     = (f3[1:0] == 2'b01) ? IMM_SH : IMM_I;
        base_we  = 1'b1;
      end
      OPC_LUI: begin
        b_sel   = B_IMM;
        kind    = IMM_U;
        base_we = 1'b1;
      end
      OPC_AUIPC: begin
        a_sel   = A_PC;
        b_sel   = B_IMM;
        kind    = IMM_U;
        base_we = 1'b1;
      end
      OPC_LOAD: begin
        a_sel   = A_RS1;
        b_sel   = B_IMM;
        base_we = 1'b1;
      end
      OPC_STORE: begin
        a_sel = A_RS1;
        b_sel = B_IMM;
        kind  = IMM_S;
      end
      OPC_BRANCH: begin
        alu_ctrl = !f3[2] ? op_SUB : f3[1] ? op_SLTU : op_SLT;
        a_sel    = A_RS1;
        b_sel    = B_RS2;
      end
      OPC_JAL, OPC_JALR: begin
        a_sel   = A_PC;
        b_sel   = B_IMM;
        kind    = IMM_4;
        base_we = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end
  assign imm   = imm_gen(kind, instr);
  assign rd_we = base_we && instr[11:7] != 5'd0;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX register feeding the ALU with decoded control, selected operands and rd metadata.
// Optional operand bypass from EX/WB enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            fwd_ex_we,
  input  logic [4:0]      fwd_ex_rd,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_wb_we,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_a,
  output logic [XLEN-1:0] out_alu_b,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal
);
  alu_op_t         dec_ctrl;
  a_sel_t          a_sel;
  b_sel_t          b_sel;
  logic [31:0]     dec_imm;
  logic            dec_we;
  logic            dec_ill;
  logic [XLEN-1:0] rs1_v;
  logic [XLEN-1:0] rs2_v;
  logic [XLEN-1:0] a_nx;
  logic [XLEN-1:0] b_nx;
  logic            capture;
  alu_ctrl_decode u_dec (
    .instr    (in_instr),
    .alu_ctrl (dec_ctrl),
    .a_sel    (a_sel),
    .b_sel    (b_sel),
    .imm      (dec_imm),
    .rd_we    (dec_we),
    .illegal  (dec_ill)
  );
`ifdef ALU_ISSUE_FWD_EN
  logic [4:0] rs1;
  logic [4:0] rs2;
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  // EX holds the younger result, so it outranks WB on a double match.
  assign rs1_v = (fwd_ex_we && fwd_ex_rd == rs1 && rs1 != 5'd0) ? fwd_ex_data :
                 (fwd_wb_we && fwd_wb_rd == rs1 && rs1 != 5'd0) ? fwd_wb_data : in_rs1_data;
  assign rs2_v = (fwd_ex_we && fwd_ex_rd == rs2 && rs2 != 5'd0) ? fwd_ex_data :
                 (fwd_wb_we && fwd_wb_rd == rs2 && rs2 != 5'd0) ? fwd_wb_data : in_rs2_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ex_we, fwd_ex_rd, fwd_ex_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data};
  assign rs1_v = in_rs1_data;
  assign rs2_v = in_rs2_data;
`endif
  assign a_nx     = a_sel == A_RS1 ? rs1_v : a_sel == A_PC ? in_pc : '0;
  assign b_nx     = b_sel == B_RS2 ? rs2_v : b_sel == B_IMM ? dec_imm : '0;
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_alu_a    <= '0;
      out_alu_b    <= '0;
      out_alu_ctrl <= '0;
      out_rs2_data <= '0;
      out_pc       <= RESET_PC;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_alu_a    <= a_nx;
      out_alu_b    <= b_nx;
      out_alu_ctrl <= dec_ctrl;
      out_rs2_data <= rs2_v;
      out_pc       <= in_pc;
      out_rd       <= in_instr[11:7];
      out_rd_we    <= dec_we;
      out_illegal  <= dec_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vector table plus handshake, flush, forwarding and async-reset sequences.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, in_rs1_data, in_rs2_data;
  logic        fwd_ex_we, fwd_wb_we;
  logic [4:0]  fwd_ex_rd, fwd_wb_rd;
  logic [31:0] fwd_ex_data, fwd_wb_data;
  logic [31:0] out_alu_a, out_alu_b, out_rs2_data, out_pc;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_illegal;
  int          n_chk = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
    .out_alu_ctrl(out_alu_ctrl), .out_rs2_data(out_rs2_data), .out_pc(out_pc),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );
  typedef struct {
    logic [31:0] instr, pc, rs1, rs2, a, b;
    logic [3:0]  ctrl;
    logic        we, ill;
  } vec_t;
  vec_t vecs[18];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input vec_t v);
    in_instr    = v.instr;
    in_pc       = v.pc;
    in_rs1_data = v.rs1;
    in_rs2_data = v.rs2;
  endtask
  initial begin
    vecs[0]  = '{32'h002081B3, 32'h40,  32'd5,        32'd7,  32'd5,        32'd7,        4'h0, 1'b1, 1'b0};
    vecs[1]  = '{32'h403100B3, 32'h44,  32'd10,       32'd4,  32'd10,       32'd4,        4'h8, 1'b1, 1'b0};
    vecs[2]  = '{32'h4030D213, 32'h48,  32'h80000000, 32'd9,  32'h80000000, 32'd3,        4'hD, 1'b1, 1'b0};
    vecs[3]  = '{32'hFFF08293, 32'h4C,  32'd1,        32'd9,  32'd1,        32'hFFFFFFFF, 4'h0, 1'b1, 1'b0};
    vecs[4]  = '{32'h01F09313, 32'h50,  32'd2,        32'd9,  32'd2,        32'd31,       4'h1, 1'b1, 1'b0};
    vecs[5]  = '{32'h0020F1B3, 32'h54,  32'hF0,       32'h3C, 32'hF0,       32'h3C,       4'h7, 1'b1, 1'b0};
    vecs[6]  = '{32'h123453B7, 32'h58,  32'h11,       32'h22, 32'd0,        32'h12345000, 4'h0, 1'b1, 1'b0};
    vecs[7]  = '{32'h00001417, 32'h100, 32'h11,       32'h22, 32'h100,      32'h1000,     4'h0, 1'b1, 1'b0};
    vecs[8]  = '{32'hFFC0A483, 32'h104, 32'h1000,     32'h22, 32'h1000,     32'hFFFFFFFC, 4'h0, 1'b1, 1'b0};
    vecs[9]  = '{32'h0020A423, 32'h108, 32'h2000,     32'h55, 32'h2000,     32'd8,        4'h0, 1'b0, 1'b0};
    vecs[10] = '{32'hFE20A823, 32'h10C, 32'h2000,     32'h55, 32'h2000,     32'hFFFFFFF0, 4'h0, 1'b0, 1'b0};
    vecs[11] = '{32'h00208063, 32'h110, 32'd3,        32'd3,  32'd3,        32'd3,        4'h8, 1'b0, 1'b0};
    vecs[12] = '{32'h0020C063, 32'h114, 32'd3,        32'd4,  32'd3,        32'd4,        4'h2, 1'b0, 1'b0};
    vecs[13] = '{32'h0020F063, 32'h118, 32'd3,        32'd4,  32'd3,        32'd4,        4'h3, 1'b0, 1'b0};
    vecs[14] = '{32'h000000EF, 32'h200, 32'd1,        32'd2,  32'h200,      32'd4,        4'h0, 1'b1, 1'b0};
    vecs[15] = '{32'h000100E7, 32'h204, 32'd1,        32'd2,  32'h204,      32'd4,        4'h0, 1'b1, 1'b0};
    vecs[16] = '{32'h00208033, 32'h208, 32'd1,        32'd2,  32'd1,        32'd2,        4'h0, 1'b0, 1'b0};
    vecs[17] = '{32'h000002FF, 32'h20C, 32'd1,        32'd2,  32'd0,        32'd0,        4'h0, 1'b0, 1'b1};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_instr = '0; in_rs1_data = '0; in_rs2_data = '0;
    fwd_ex_we = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0;
    fwd_wb_we = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ctrl", {28'b0, out_alu_ctrl}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      logic [31:0] ins;
      ins = vecs[i].instr;
      drive(vecs[i]);
      step();
      check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("v%0d_a", i), out_alu_a, vecs[i].a);
      check($sformatf("v%0d_b", i), out_alu_b, vecs[i].b);
      check($sformatf("v%0d_ctrl", i), {28'b0, out_alu_ctrl}, {28'b0, vecs[i].ctrl});
      check($sformatf("v%0d_rd_we", i), {31'b0, out_rd_we}, {31'b0, vecs[i].we});
      check($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].ill});
      check($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
      check($sformatf("v%0d_rs2", i), out_rs2_data, vecs[i].rs2);
      check($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, ins[11:7]});
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(vecs[0]);
    in_valid = 1'b1;
    step();
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    drive(vecs[1]);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      check($sformatf("bp%0d_valid", k), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp%0d_a", k), out_alu_a, 32'd5);
      check($sformatf("bp%0d_ctrl", k), {28'b0, out_alu_ctrl}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("bp_next_ctrl", {28'b0, out_alu_ctrl}, 32'd8);
    check("bp_next_a", out_alu_a, 32'd10);
    in_valid = 1'b0;
    step();
    check("bp_drop", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(vecs[0]);
    in_valid = 1'b1;
    step();
    check("fl_pre_valid", {31'b0, out_valid}, 32'd1);
    drive(vecs[1]);
    flush = 1'b1;
    step();
    check("fl_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    check("fl_no_capture", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    drive(vecs[0]);
    in_valid = 1'b1;
    fwd_ex_we = 1'b1; fwd_ex_rd = 5'd1; fwd_ex_data = 32'hAA;
    fwd_wb_we = 1'b1; fwd_wb_rd = 5'd1; fwd_wb_data = 32'hBB;
    step();
`ifdef ALU_ISSUE_FWD_EN
    check("fwd_ex_wins", out_alu_a, 32'hAA);
`else
    check("fwd_ignored_ex", out_alu_a, 32'd5);
`endif
    fwd_ex_we = 1'b0;
    step();
`ifdef ALU_ISSUE_FWD_EN
    check("fwd_wb_a", out_alu_a, 32'hBB);
`else
    check("fwd_ignored_wb", out_alu_a, 32'd5);
`endif
    in_instr = 32'h002001B3;
    fwd_ex_we = 1'b1; fwd_ex_rd = 5'd0;
    fwd_wb_rd = 5'd2; fwd_wb_data = 32'hCC;
    step();
    check("fwd_x0_a", out_alu_a, 32'd5);
`ifdef ALU_ISSUE_FWD_EN
    check("fwd_wb_b", out_alu_b, 32'hCC);
    check("fwd_wb_rs2", out_rs2_data, 32'hCC);
`else
    check("fwd_ignored_b", out_alu_b, 32'd7);
    check("fwd_ignored_rs2", out_rs2_data, 32'd7);
`endif
    fwd_ex_we = 1'b0; fwd_wb_we = 1'b0;
    out_ready = 1'b0;
    drive(vecs[7]);
    step();
    check("ar_pre_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_a", out_alu_a, 32'd0);
    check("ar_b", out_alu_b, 32'd0);
    check("ar_pc", out_pc, 32'd0);
    check("ar_rd", {27'b0, out_rd}, 32'd0);
    check("ar_rd_we", {31'b0, out_rd_we}, 32'd0);
    check("ar_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_after_valid", {31'b0, out_valid}, 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
